// File: rtl/sram_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : sram_slave_param
// Purpose  : Single-port synchronous SRAM slave with byte write strobes,
//            out-of-range address detection and a parameterisable read
//            latency. Writes complete in one cycle and may be issued every
//            cycle. A read blocks further requests until its data is
//            returned RD_LAT cycles after acceptance.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W    address width in bits
//   DATA_W    data width in bits (multiple of 8, 8..64)
//   DEPTH     number of words (1..2**ADDR_W)
//   RD_LAT    read latency in cycles (1..4)
// Ports
//   clk       clock, all logic on the rising edge
//   rst       synchronous active-high reset (storage is not cleared)
//   scs       request present
//   swrite    1 = write, 0 = read (qualified by scs)
//   saddr     word address
//   sdatain   write data
//   sstrb     byte write enables, bit i covers sdatain[8i+7:8i]
//   sready    slave accepts a request this cycle
//   swack     one-cycle write acknowledge
//   srvalid   one-cycle read data valid
//   srdataout read data, holds its last valid value between reads
//   serr      out-of-range flag, only ever high alongside swack or srvalid
// ============================================================================
module sram_slave_param #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scs,
  input  logic                swrite,
  input  logic [ADDR_W-1:0]   saddr,
  input  logic [DATA_W-1:0]   sdatain,
  input  logic [DATA_W/8-1:0] sstrb,
  output logic                sready,
  output logic                swack,
  output logic                srvalid,
  output logic [DATA_W-1:0]   srdataout,
  output logic                serr
);

  localparam int c_NBYTES = DATA_W / 8;
  localparam int c_CNT_W  = $clog2(RD_LAT + 1);
  localparam int c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH may equal 2**ADDR_W, so the range compare is done one bit wider.
  localparam logic [ADDR_W:0]    c_DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(RD_LAT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_RBUSY = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Storage and address decode
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic               w_in_range;
  logic [c_IDX_W-1:0] w_idx;
  logic [DATA_W-1:0]  w_rd_word;
  logic               w_accept;

  state_t              state_q, state_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic                swack_q, swack_d;
  logic                srvalid_q, srvalid_d;
  logic                serr_q, serr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic                rerr_q, rerr_d;

  assign w_in_range = ({1'b0, saddr} < c_DEPTH_X);
  assign w_idx      = saddr[c_IDX_W-1:0];
  // Out-of-range reads return zeros rather than whatever the index aliases to.
  assign w_rd_word  = w_in_range ? mem_q[w_idx] : '0;
  assign w_accept   = scs && (state_q == ST_IDLE);

  // Storage has no reset; a request coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && swrite && w_in_range) begin
      for (int b = 0; b < c_NBYTES; b++) begin
        if (sstrb[b]) begin
          mem_q[w_idx][8*b +: 8] <= sdatain[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      swack_q   <= 1'b0;
      srvalid_q <= 1'b0;
      serr_q    <= 1'b0;
      rdata_q   <= '0;
      rbuf_q    <= '0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      swack_q   <= swack_d;
      srvalid_q <= srvalid_d;
      serr_q    <= serr_d;
      rdata_q   <= rdata_d;
      rbuf_q    <= rbuf_d;
      rerr_q    <= rerr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and response generation
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    swack_d   = 1'b0;
    srvalid_d = 1'b0;
    serr_d    = 1'b0;
    rdata_d   = rdata_q;
    rbuf_d    = rbuf_q;
    rerr_d    = rerr_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (swrite) begin
            swack_d = 1'b1;
            serr_d  = !w_in_range;
          end else if (RD_LAT == 1) begin
            // Single-cycle read: respond directly, never leave IDLE.
            srvalid_d = 1'b1;
            serr_d    = !w_in_range;
            rdata_d   = w_rd_word;
          end else begin
            // Data is snapshotted now so a write accepted in the srvalid
            // cycle cannot disturb it. The counter counts edges since accept.
            state_d = ST_RBUSY;
            cnt_d   = c_ONE;
            rbuf_d  = w_rd_word;
            rerr_d  = !w_in_range;
          end
        end
      end

      ST_RBUSY: begin
        if (cnt_q == c_LAST) begin
          // Return to IDLE on the same edge that raises srvalid, so sready
          // is already high during the data cycle.
          state_d   = ST_IDLE;
          cnt_d     = '0;
          srvalid_d = 1'b1;
          serr_d    = rerr_q;
          rdata_d   = rbuf_q;
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sready    = (state_q == ST_IDLE);
  assign swack     = swack_q;
  assign srvalid   = srvalid_q;
  assign serr      = serr_q;
  assign srdataout = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_slave_param
// Purpose  : Self-checking bench for sram_slave_param. Three instances cover
//            the default configuration, a 32-bit / DEPTH=200 / RD_LAT=3
//            variant and a 16-bit / RD_LAT=4 variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_slave_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: defaults (8b data, RD_LAT=1) ----------------
  logic       a_rst, a_scs, a_wr;
  logic [7:0] a_addr, a_din;
  logic [0:0] a_strb;
  logic       a_rdy, a_wack, a_rv, a_err;
  logic [7:0] a_dout;

  sram_slave_param u_a (
    .clk(clk), .rst(a_rst), .scs(a_scs), .swrite(a_wr), .saddr(a_addr),
    .sdatain(a_din), .sstrb(a_strb), .sready(a_rdy), .swack(a_wack),
    .srvalid(a_rv), .srdataout(a_dout), .serr(a_err)
  );

  // ---------------- instance B: 32b, DEPTH=200, RD_LAT=3 --------------------
  localparam int B_LAT   = 3;
  localparam int B_DEPTH = 200;
  logic        b_rst, b_scs, b_wr;
  logic [7:0]  b_addr;
  logic [31:0] b_din;
  logic [3:0]  b_strb;
  logic        b_rdy, b_wack, b_rv, b_err;
  logic [31:0] b_dout;

  sram_slave_param #(.ADDR_W(8), .DATA_W(32), .DEPTH(B_DEPTH), .RD_LAT(B_LAT)) u_b (
    .clk(clk), .rst(b_rst), .scs(b_scs), .swrite(b_wr), .saddr(b_addr),
    .sdatain(b_din), .sstrb(b_strb), .sready(b_rdy), .swack(b_wack),
    .srvalid(b_rv), .srdataout(b_dout), .serr(b_err)
  );

  // ---------------- instance C: 16b, RD_LAT=4 -------------------------------
  logic        c_rst, c_scs, c_wr;
  logic [7:0]  c_addr;
  logic [15:0] c_din;
  logic [1:0]  c_strb;
  logic        c_rdy, c_wack, c_rv, c_err;
  logic [15:0] c_dout;

  sram_slave_param #(.DATA_W(16), .RD_LAT(4)) u_c (
    .clk(clk), .rst(c_rst), .scs(c_scs), .swrite(c_wr), .saddr(c_addr),
    .sdatain(c_din), .sstrb(c_strb), .sready(c_rdy), .swack(c_wack),
    .srvalid(c_rv), .srdataout(c_dout), .serr(c_err)
  );

  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Reference model for instance B: a word array plus the cycle numbers at
  // which each response is due. Cycle e is the interval after edge e.
  // --------------------------------------------------------------------------
  logic [31:0] m_b [B_DEPTH];
  int          e_b        = 0;
  int          ready_from = 0;
  int          wack_at    = -1;
  int          rv_at      = -1;
  bit          werr_b, rerr_b;
  logic [31:0] rpend_b;
  logic [31:0] last_b     = '0;
  bit          prev_rdy_b = 1'b0;

  task automatic b_cycle(input bit rst_v, input bit scs_v, input bit wr_v,
                         input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    bit acc, x_rdy, x_wack, x_rv, x_err;
    b_rst = rst_v; b_scs = scs_v; b_wr = wr_v; b_addr = a; b_din = d; b_strb = s;
    acc = !rst_v && scs_v && prev_rdy_b;
    tick();
    e_b++;
    if (rst_v) begin
      ready_from = e_b; wack_at = -1; rv_at = -1; last_b = '0;
    end else if (acc) begin
      if (wr_v) begin
        wack_at = e_b;
        werr_b  = (int'(a) >= B_DEPTH);
        if (!werr_b)
          for (int b = 0; b < 4; b++)
            if (s[b]) m_b[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        rv_at      = e_b + B_LAT - 1;
        ready_from = e_b + B_LAT - 1;
        rerr_b     = (int'(a) >= B_DEPTH);
        rpend_b    = rerr_b ? 32'h0 : m_b[a];
      end
    end
    x_rdy  = (e_b >= ready_from);
    x_wack = (e_b == wack_at);
    x_rv   = (e_b == rv_at);
    if (x_rv) last_b = rpend_b;
    x_err  = x_wack ? werr_b : (x_rv ? rerr_b : 1'b0);
    chk("b_sready",    b_rdy,  x_rdy);
    chk("b_swack",     b_wack, x_wack);
    chk("b_srvalid",   b_rv,   x_rv);
    chk("b_serr",      b_err,  x_err);
    chk("b_srdataout", b_dout, last_b);
    prev_rdy_b = x_rdy;
  endtask

  // --------------------------------------------------------------------------
  // Vector table for instance A: one row per cycle, expected outputs are
  // those visible in the cycle after the row's edge.
  // --------------------------------------------------------------------------
  typedef struct {
    logic       rst, scs, wr;
    logic [7:0] addr, din;
    logic       strb;
    logic       e_rdy, e_wack, e_rv, e_err;
    logic [7:0] e_dout;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic c, input logic w,
                               input logic [7:0] a, input logic [7:0] d, input logic s,
                               input logic wk, input logic rv, input logic [7:0] q);
    vec_t v;
    v.rst = r; v.scs = c; v.wr = w; v.addr = a; v.din = d; v.strb = s;
    v.e_rdy = 1'b1; v.e_wack = wk; v.e_rv = rv; v.e_err = 1'b0; v.e_dout = q;
    return v;
  endfunction

  vec_t tbl [14];

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] last_w;
    logic [7:0] dw;

    a_rst = 1; a_scs = 0; a_wr = 0; a_addr = 0; a_din = 0; a_strb = 0;
    b_rst = 1; b_scs = 0; b_wr = 0; b_addr = 0; b_din = 0; b_strb = 0;
    c_rst = 1; c_scs = 0; c_wr = 0; c_addr = 0; c_din = 0; c_strb = 0;

    //             rst scs wr  addr   din    strb wack rv  dout
    tbl[0]  = mkv(1, 0, 0, 8'h00, 8'h00, 0,   0,   0, 8'h00); // reset state
    tbl[1]  = mkv(0, 1, 1, 8'h10, 8'hA5, 1,   1,   0, 8'h00); // write A5
    tbl[2]  = mkv(0, 1, 0, 8'h10, 8'h00, 0,   0,   1, 8'hA5); // read back
    tbl[3]  = mkv(0, 0, 0, 8'h00, 8'h00, 0,   0,   0, 8'hA5); // data holds
    tbl[4]  = mkv(0, 1, 1, 8'h10, 8'h3C, 0,   1,   0, 8'hA5); // no strobes
    tbl[5]  = mkv(0, 1, 0, 8'h10, 8'h00, 0,   0,   1, 8'hA5); // unchanged
    tbl[6]  = mkv(0, 1, 1, 8'h20, 8'h5A, 1,   1,   0, 8'hA5);
    tbl[7]  = mkv(1, 1, 1, 8'h20, 8'h00, 1,   0,   0, 8'h00); // rst wins
    tbl[8]  = mkv(0, 1, 0, 8'h20, 8'h00, 0,   0,   1, 8'h5A);
    tbl[9]  = mkv(0, 1, 1, 8'h00, 8'h11, 1,   1,   0, 8'h5A);
    tbl[10] = mkv(1, 1, 1, 8'h00, 8'h99, 1,   0,   0, 8'h00); // rst + write 0
    tbl[11] = mkv(0, 1, 0, 8'h00, 8'h00, 0,   0,   1, 8'h11); // prior value
    tbl[12] = mkv(0, 0, 1, 8'h00, 8'h44, 1,   0,   0, 8'h11); // scs=0 ignored
    tbl[13] = mkv(0, 1, 0, 8'h00, 8'h00, 0,   0,   1, 8'h11);

    // Global reset; instance B is stepped through its model.
    b_cycle(1, 0, 0, 0, 0, 0);
    b_cycle(1, 0, 0, 0, 0, 0);
    a_rst = 0; c_rst = 0;

    // ---------------- A: table ----------------
    for (int i = 0; i < 14; i++) begin
      a_rst = tbl[i].rst; a_scs = tbl[i].scs; a_wr = tbl[i].wr;
      a_addr = tbl[i].addr; a_din = tbl[i].din; a_strb = tbl[i].strb;
      tick();
      chk($sformatf("a_vec%0d_sready", i),  a_rdy,  tbl[i].e_rdy);
      chk($sformatf("a_vec%0d_swack", i),   a_wack, tbl[i].e_wack);
      chk($sformatf("a_vec%0d_srvalid", i), a_rv,   tbl[i].e_rv);
      chk($sformatf("a_vec%0d_serr", i),    a_err,  tbl[i].e_err);
      chk($sformatf("a_vec%0d_dout", i),    a_dout, tbl[i].e_dout);
    end
    a_rst = 0; a_scs = 0;

    // ---------------- A: alternate write/read on addr 3 every cycle --------
    last_w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      a_scs = 1; a_addr = 8'h03; a_strb = 1'b1;
      a_wr  = (i % 2 == 0);
      dw    = 8'(i * 37 + 5);
      a_din = dw;
      tick();
      chk("alt_sready", a_rdy, 1'b1);
      if (i % 2 == 0) begin
        chk("alt_swack", a_wack, 1'b1);
        last_w = dw;
      end else begin
        chk("alt_srvalid", a_rv, 1'b1);
        chk("alt_data", a_dout, last_w);
      end
    end
    a_scs = 0;
    tick();
    chk("alt_after_sready", a_rdy, 1'b1);

    // ---------------- C: RD_LAT=4 latency and abort -------------------------
    c_scs = 1; c_wr = 1; c_addr = 8'h07; c_din = 16'hBEEF; c_strb = 2'b11;
    tick();
    c_scs = 0;
    chk("c_wr_swack", c_wack, 1'b1);
    c_scs = 1; c_wr = 0;
    tick();                    // accept edge k
    c_scs = 0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("c_lat_sready%0d", j), c_rdy, 1'b0);
      chk($sformatf("c_lat_rv%0d", j),     c_rv,  1'b0);
      tick();
    end
    chk("c_lat_rv", c_rv, 1'b1);
    chk("c_lat_data", c_dout, 16'hBEEF);
    chk("c_lat_sready_rv", c_rdy, 1'b1);
    tick();
    chk("c_rv_one_cycle", c_rv, 1'b0);

    c_scs = 1; c_wr = 0; c_addr = 8'h07;
    tick();                    // accept edge k
    c_scs = 0;
    chk("c_ab_busy", c_rdy, 1'b0);
    tick();                    // edge k+1
    chk("c_ab_rv_k1", c_rv, 1'b0);
    c_rst = 1;
    tick();                    // edge k+2 with reset
    c_rst = 0;
    chk("c_ab_sready", c_rdy, 1'b1);
    chk("c_ab_dout", c_dout, 16'h0);
    chk("c_ab_rv", c_rv, 1'b0);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("c_ab_no_rv", c_rv, 1'b0);
      chk("c_ab_dout_hold", c_dout, 16'h0);
    end
    c_scs = 1; c_wr = 0; c_addr = 8'h07;
    tick();
    c_scs = 0;
    tick(); tick(); tick();
    chk("c_keep_rv", c_rv, 1'b1);
    chk("c_keep_data", c_dout, 16'hBEEF);

    // ---------------- B: fill memory with known contents -------------------
    for (int i = 0; i < B_DEPTH; i++)
      b_cycle(0, 1, 1, 8'(i), $urandom, 4'hF);

    // Byte strobes and RD_LAT=3 timing
    b_cycle(0, 1, 1, 8'd4, 32'h11223344, 4'hF);
    b_cycle(0, 1, 1, 8'd4, 32'hFFFFFFFF, 4'b0101);
    b_cycle(0, 1, 0, 8'd4, 32'h0, 4'h0);
    chk("b035_busy0", b_rdy, 1'b0);
    b_cycle(0, 0, 0, 0, 0, 0);
    chk("b035_busy1", b_rdy, 1'b0);
    b_cycle(0, 0, 0, 0, 0, 0);
    chk("b035_rv", b_rv, 1'b1);
    chk("b035_data", b_dout, 32'h11FF33FF);
    chk("b035_ready", b_rdy, 1'b1);

    // Out-of-range write and read
    b_cycle(0, 1, 1, 8'd250, 32'h77, 4'hF);
    chk("b036_wack", b_wack, 1'b1);
    chk("b036_werr", b_err, 1'b1);
    b_cycle(0, 1, 0, 8'd250, 32'h0, 4'h0);
    b_cycle(0, 0, 0, 0, 0, 0);
    b_cycle(0, 0, 0, 0, 0, 0);
    chk("b036_rv", b_rv, 1'b1);
    chk("b036_rerr", b_err, 1'b1);
    chk("b036_rdata", b_dout, 32'h0);
    // Every in-range word still matches the model
    for (int i = 0; i < B_DEPTH; i++) begin
      b_cycle(0, 1, 0, 8'(i), 32'h0, 4'h0);
      b_cycle(0, 0, 0, 0, 0, 0);
      b_cycle(0, 0, 0, 0, 0, 0);
    end

    // ---------------- B: randomized traffic --------------------------------
    for (int i = 0; i < 500; i++) begin
      b_cycle(($urandom_range(0, 63) == 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)),
              $urandom,
              4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_slave_param.md
SRAM_SLAVE_PARAM -- requirements
Module: sram_slave_param

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, address width in bits.
REQ-002 SHALL provide parameter DATA_W, default 8, data width in bits; legal values are multiples of 8 in the range 8..64.
REQ-003 SHALL provide parameter DEPTH, default 256, number of words; legal range is 1..2**ADDR_W.
REQ-004 SHALL provide parameter RD_LAT, default 1, read latency in cycles; legal range is 1..4.
REQ-005 SHALL provide port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL provide port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL provide port scs, input, 1 bit, slave chip select (request present).
REQ-008 SHALL provide port swrite, input, 1 bit; 1 = write, 0 = read; qualified by scs.
REQ-009 SHALL provide port saddr, input, ADDR_W bits, word address.
REQ-010 SHALL provide port sdatain, input, DATA_W bits, write data.
REQ-011 SHALL provide port sstrb, input, DATA_W/8 bits, byte write enables; bit i covers sdatain[8i+7:8i].
REQ-012 SHALL provide port sready, output, 1 bit; slave can accept a request this cycle.
REQ-013 SHALL provide port swack, output, 1 bit, one-cycle write acknowledge.
REQ-014 SHALL provide port srvalid, output, 1 bit, one-cycle read data valid.
REQ-015 SHALL provide port srdataout, output, DATA_W bits, read data.
REQ-016 SHALL provide port serr, output, 1 bit, error flag for an out-of-range address; it accompanies swack or srvalid.

Function
REQ-017 SHALL implement storage of DEPTH x DATA_W words; contents are not cleared by rst.
REQ-018 SHALL accept a request at a rising edge when scs=1, sready=1 and rst=0 ("accept edge" k); when scs=0 there is no effect.
REQ-019 SHALL implement a two-state FSM: IDLE (sready=1) and RBUSY (sready=0).
REQ-020 SHALL handle an accepted write (in-range address) as follows: at edge k, update each byte whose sstrb bit is 1; leave bytes with sstrb=0 unchanged; stay in IDLE.
REQ-021 SHALL drive swack=1 for exactly the cycle following edge k; sready SHALL stay 1, so back-to-back writes every cycle are legal.
REQ-022 SHALL handle an accepted read by capturing memory[saddr] at edge k and moving to RBUSY.
REQ-023 SHALL drive srvalid=1 with the captured data on srdataout for exactly the cycle following edge k+RD_LAT-1; the FSM SHALL return to IDLE at that same edge, so sready=1 in the srvalid cycle.
REQ-024 SHALL, for RD_LAT=1, hold IDLE after the read: sready stays 1, and the srvalid cycle is the cycle after edge k.
REQ-025 SHALL make a write accepted in the srvalid cycle of a read leave that read's data unaffected.
REQ-026 SHALL make a read at edge k return data that includes all writes accepted at edges before k.
REQ-027 SHALL keep srdataout equal to its last valid value when srvalid=0.
REQ-028 SHALL treat saddr >= DEPTH as out of range: a write SHALL leave memory unchanged, and a read SHALL return all zeros; in both cases, with normal timing, serr=1 alongside swack or srvalid.
REQ-029 SHALL drive serr=0 whenever swack=0 and srvalid=0.
REQ-030 SHALL use a latency counter of width ceil(log2(RD_LAT+1)); the counter SHALL neither wrap nor go beyond RD_LAT.

Reset
REQ-031 SHALL, at an edge with rst=1, set FSM to IDLE, sready=1, swack=0, srvalid=0, serr=0, srdataout=0 and the latency counter to 0.
REQ-032 SHALL give rst priority over a simultaneous request; that request is discarded with no memory update.
REQ-033 SHALL make rst during RBUSY abort the read: no srvalid is issued for it.

Verification
REQ-034 SHALL cover this case: defaults; write addr 0x10 data 0xA5 sstrb=1, then read 0x10 -> swack in the cycle after the write; srvalid with 0xA5 in the cycle after the read accept.
REQ-035 SHALL cover this case: DATA_W=32, RD_LAT=3; write 0x11223344 to addr 4, then write 0xFFFFFFFF with sstrb=4'b0101, then read addr 4 -> 0x11FF33FF; srvalid 3 cycles after accept; sready low for exactly 2 cycles.
REQ-036 SHALL cover this case: DEPTH=200; write 0x77 to addr 250, then read addr 250 -> serr=1 with swack; serr=1 with srvalid and data 0x00; memory words 0..199 unchanged.
REQ-037 SHALL cover this case: RD_LAT=1; alternate write and read every cycle on addr 3 for 8 cycles -> sready never 0; each read returns the preceding write's data.
REQ-038 SHALL cover this case: RD_LAT=4; rst asserted 2 cycles after read accept -> no srvalid; sready=1 and srdataout=0 after reset; memory contents preserved.
REQ-039 SHALL cover this case: rst and a write to addr 0 asserted on the same edge -> no swack; a later read of addr 0 returns the prior value.
